uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  UART transmit framer, the TX-side counterpart of the UART_RX receive chain.
//  Accepts one parallel byte and serialises it LSB-first as start | data | [parity] | stop[s].
//  Sends one bit per clk_TX cycle; clk_TX is the already-divided baud clock from the clock divider.
//  Sits between the SYS_CTRL/FIFO read side and the TX_OUT pad.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame
// PORTS
//  clk_TX      in   1           TX baud clock; single clock domain, all logic on posedge
//  rst         in   1           synchronous, active-high reset
//  P_DATA      in   DATA_WIDTH  parallel payload, valid with Data_Valid
//  Data_Valid  in   1           request to send P_DATA; accepted only when Busy==0
//  PAR_EN      in   1           1: insert parity bit after data
//  PAR_TYP     in   1           0: even parity, 1: odd parity
//  TX_OUT      out  1           serial line, registered, idles high
//  Busy        out  1           high from first start-bit cycle through last stop-bit cycle
// BEHAVIOUR
//  - Reset (rst==1 at posedge): state=IDLE, TX_OUT=1, Busy=0, bit counter=0, data reg=0.
//  - Reset mid-frame aborts the frame; TX_OUT=1 and Busy=0 from the next cycle, no partial stop bit.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    IDLE  : TX_OUT=1, Busy=0. Data_Valid==1 at edge k -> latch P_DATA, PAR_EN, PAR_TYP -> START.
//    START : TX_OUT=0 during cycle k+1 (one-cycle latency from accept), Busy=1 -> DATA.
//    DATA  : TX_OUT=data[cnt], cnt 0..DATA_WIDTH-1, one cycle per bit, LSB first.
//            At cnt==DATA_WIDTH-1 -> PARITY if latched PAR_EN, else STOP; cnt clears.
//    PARITY: TX_OUT = ^data XOR latched PAR_TYP (even: XOR of data; odd: inverted) -> STOP.
//    STOP  : TX_OUT=1, Busy=1, one cycle -> IDLE.
//  - Frame length = 1 + DATA_WIDTH + PAR_EN + 1 cycles (10 or 11 for DATA_WIDTH=8).
//  - Busy and TX_OUT are registered outputs that change together on the same edge.
//  - Data_Valid while Busy==1 is ignored (no queueing); P_DATA/PAR_* changes mid-frame have no effect.
//  - Parity is computed from the latched byte, never from live P_DATA.
//  - Back-to-back: after STOP the FSM spends >=1 cycle in IDLE (TX_OUT=1); Data_Valid held high
//    there starts the next frame, so min frame spacing is 1 idle cycle.
//  - Counter is $clog2(DATA_WIDTH) bits wide; no wrap beyond DATA_WIDTH-1.
//  - No illegal-state lockup: any undefined state encoding returns to IDLE with TX_OUT=1.
// CONFIGURATION
//  UART_TX_STOP2_EN defined: STOP lasts 2 cycles (two stop bits), Busy stays high for both;
//    frame = 2 + DATA_WIDTH + PAR_EN + 1 cycles.
//  UART_TX_STOP2_EN undefined: single stop bit as above; no second-stop logic is synthesised.
// TESTING
//  1 rst=1 two cycles -> TX_OUT=1, Busy=0; Data_Valid=1 during reset -> no frame starts.
//  2 P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT 0,1,0,1,0,0,1,0,1,1 on the
//    next 10 cycles, Busy=1 for exactly those 10, then TX_OUT=1, Busy=0.
//  3 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; repeat with PAR_TYP=1 -> parity
//    bit 1; 11-cycle frame each.
//  4 P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> start, 8x0, parity 1, stop 1; change P_DATA to
//    0xFF in cycle 3 -> serial data unchanged.
//  5 Data_Valid held high across two frames (0x3C then 0xC3) -> 2nd start bit exactly
//    1 idle cycle after 1st stop; pulses while Busy ignored.
//  6 rst=1 during data bit 4 -> TX_OUT=1, Busy=0 next cycle; new request afterwards sends a
//    clean full frame. Rerun 2 with UART_TX_STOP2_EN -> 11-cycle frame ending 1,1.

Source files
------------

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame
//  Description : UART transmit framer. Accepts one parallel byte when idle
//                and serialises it LSB-first as
//                  start(0) | data[0..DATA_WIDTH-1] | [parity] | stop(1)[x2]
//                with one bit per clk_TX cycle (clk_TX is the baud clock).
//  Parameters  : DATA_WIDTH  payload bits per frame (default 8)
//  Ports       : clk_TX      in   baud clock, all logic on posedge
//                rst         in   synchronous active-high reset
//                P_DATA      in   parallel payload, sampled with Data_Valid
//                Data_Valid  in   send request, accepted only while idle
//                PAR_EN      in   1: append parity bit after the data
//                PAR_TYP     in   0: even parity, 1: odd parity
//                TX_OUT      out  registered serial line, idles high
//                Busy        out  registered, high for the whole frame
//  Build macro : UART_TX_STOP2_EN  when defined, two stop bits are sent
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_TX,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int              c_CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_cnt_next;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    w_latch;
    logic                    w_parity;
    logic                    r_tx;
    logic                    r_busy;
    logic                    w_tx_next;
    logic                    w_busy_next;

`ifdef UART_TX_STOP2_EN
    // Marks that the first of the two stop cycles has already been sent.
    logic                    r_stop_second;
    logic                    w_stop_second_next;
`endif

    // Parity always comes from the latched byte, never from live P_DATA.
    assign w_parity = (^r_data) ^ r_par_typ;

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
`ifdef UART_TX_STOP2_EN
        w_stop_second_next = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (Data_Valid) begin
                    w_latch      = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_cnt_next   = '0;
                w_state_next = S_DATA;
            end
            S_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                w_state_next = S_STOP;
            end
            S_STOP: begin
`ifdef UART_TX_STOP2_EN
                if (!r_stop_second) begin
                    w_stop_second_next = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            default: begin
                // Undefined encodings recover straight to idle.
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the *next* state so TX_OUT/Busy are registered
    // and change on the same edge as the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b1;
        case (w_state_next)
            S_IDLE:   w_busy_next = 1'b0;
            S_START:  w_tx_next   = 1'b0;
            // r_data is already latched: DATA is never entered from IDLE.
            S_DATA:   w_tx_next   = r_data[w_cnt_next];
            S_PARITY: w_tx_next   = w_parity;
            S_STOP:   w_tx_next   = 1'b1;
            default:  w_busy_next = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_TX) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
            if (w_latch) begin
                r_data    <= P_DATA;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
            end
        end
    end

`ifdef UART_TX_STOP2_EN
    always_ff @(posedge clk_TX) begin
        if (rst) begin
            r_stop_second <= 1'b0;
        end else begin
            r_stop_second <= w_stop_second_next;
        end
    end
`endif

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_frame
//  Description : Directed scoreboard testbench for uart_tx_frame. Expected
//                per-cycle {TX_OUT, Busy} pairs are queued when a request is
//                driven and popped/compared each cycle on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_frame;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic          tx_out;
    logic          busy;

    int            checks   = 0;
    int            failures = 0;
    logic [1:0]    sb[$];

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .clk_TX     (clk),
        .rst        (rst),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .TX_OUT     (tx_out),
        .Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the expected per-cycle {tx, busy} pairs of one frame.
    task automatic push_frame(input logic [DW-1:0] d, input logic pe,
                              input logic pt, input logic with_idle);
        logic p;
        sb.push_back(2'b01);                 // start
        p = pt;
        for (int i = 0; i < DW; i++) begin
            sb.push_back({d[i], 1'b1});
            p = p ^ d[i];
        end
        if (pe) sb.push_back({p, 1'b1});
        sb.push_back(2'b11);                 // stop
`ifdef UART_TX_STOP2_EN
        sb.push_back(2'b11);                 // second stop
`endif
        if (with_idle) sb.push_back(2'b10);
    endtask

    // Compare n cycles against the scoreboard, sampling on the falling edge.
    task automatic check_n(input int n, input string tag);
        logic [1:0] obs;
        logic [1:0] exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs = {tx_out, busy};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $error("FAIL %s cycle %0d scoreboard empty, tx/busy got=%b", tag, i, obs);
            end else begin
                exp = sb.pop_front();
                assert (obs === exp) else begin
                    failures++;
                    $error("FAIL %s cycle %0d tx/busy got=%b expected=%b", tag, i, obs, exp);
                end
            end
        end
    endtask

    function automatic int frame_len(input logic pe);
        int n;
        n = DW + 2 + (pe ? 1 : 0);
`ifdef UART_TX_STOP2_EN
        n = n + 1;
`endif
        return n;
    endfunction

    initial begin
        rst        = 1'b1;
        data_valid = 1'b1;   // request during reset must be ignored
        p_data     = 8'h5A;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        // 1: reset, with Data_Valid asserted throughout
        @(negedge clk);
        sb.push_back(2'b10);
        sb.push_back(2'b10);
        check_n(2, "reset");
        rst        = 1'b0;
        data_valid = 1'b0;
        sb.push_back(2'b10);
        sb.push_back(2'b10);
        check_n(2, "post_reset_idle");

        // 2: 0xA5, no parity
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        push_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check_n(1, "a5_nopar");
        data_valid = 1'b0;
        check_n(frame_len(1'b0), "a5_nopar");

        // 3: 0xA5 even parity, then odd parity
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        push_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check_n(1, "a5_even");
        data_valid = 1'b0;
        check_n(frame_len(1'b1), "a5_even");

        par_typ = 1'b1; data_valid = 1'b1;
        push_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        check_n(1, "a5_odd");
        data_valid = 1'b0;
        check_n(frame_len(1'b1), "a5_odd");

        // 4: 0x00 odd parity, inputs changed mid-frame
        p_data = 8'h00; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
        push_frame(8'h00, 1'b1, 1'b1, 1'b1);
        check_n(1, "zero_odd");
        data_valid = 1'b0;
        check_n(2, "zero_odd");
        p_data = 8'hFF; par_typ = 1'b0; par_en = 1'b0;
        check_n(frame_len(1'b1) - 2, "zero_odd");

        // 5: Data_Valid held high across two frames
        p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        push_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        sb.push_back(2'b10);
        push_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        check_n(2, "b2b_first");
        p_data = 8'hC3;       // must not disturb the frame in flight
        check_n(frame_len(1'b0) - 2 + 1 + 1, "b2b_first");
        data_valid = 1'b0;
        check_n(frame_len(1'b0), "b2b_second");

        // 6: reset during data bit 4, then a clean frame
        p_data = 8'h5A; par_en = 1'b0; data_valid = 1'b1;
        push_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check_n(1, "abort");
        data_valid = 1'b0;
        check_n(5, "abort");  // d0..d4 seen
        rst = 1'b1;
        sb.delete();
        sb.push_back(2'b10);
        check_n(1, "abort_reset");
        rst = 1'b0;
        sb.push_back(2'b10);
        check_n(1, "abort_idle");

        p_data = 8'h96; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        push_frame(8'h96, 1'b1, 1'b0, 1'b1);
        check_n(1, "after_abort");
        data_valid = 1'b0;
        check_n(frame_len(1'b1), "after_abort");

        // Every queued expectation must have been consumed.
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain leftover=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
